// File: rtl/stack_pkg.sv
// Shared types and helpers for the parametrised LIFO stack.
package stack_pkg;

  // Decoded operation for one clock edge, in priority order of evaluation.
  typedef enum logic [2:0] {
    OP_NONE    = 3'd0,
    OP_CLEAR   = 3'd1,
    OP_PUSH    = 3'd2,
    OP_POP     = 3'd3,
    OP_REPLACE = 3'd4,
    OP_OVF     = 3'd5,
    OP_UNF     = 3'd6
  } stack_op_t;

  // Bits needed to hold an entry count from 0 up to and including depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stack_regfile.sv
// Stack storage: one synchronous write port, one asynchronous read port, no reset.
module stack_regfile
  import stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write the addressed entry; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO stack: push, pop, replace, sync clear, status and sticky errors.
module param_stack
  import stack_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  localparam int CW      = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  input  logic             err_clr,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             done,
  output logic             err_overflow,
  output logic             err_underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]    sp_r;
  logic             done_r;
  logic             ovf_r;
  logic             unf_r;
  stack_op_t        op_s;
  logic             empty_s;
  logic             full_s;
  logic             we_s;
  logic [AW-1:0]    waddr_s;
  logic [AW-1:0]    raddr_s;
  logic [WIDTH-1:0] rdata_s;

  // Status is a pure function of the registered stack pointer.
  assign empty_s = (sp_r == {CW{1'b0}});
  assign full_s  = (sp_r == CW'(DEPTH));

  // Decode the request into exactly one operation; clear dominates everything.
  always_comb begin
    op_s = OP_NONE;
    if (clear) begin
      op_s = OP_CLEAR;
    end else if (push && pop) begin
      op_s = empty_s ? OP_PUSH : OP_REPLACE;
    end else if (push) begin
      op_s = full_s ? OP_OVF : OP_PUSH;
    end else if (pop) begin
      op_s = empty_s ? OP_UNF : OP_POP;
    end else begin
      op_s = OP_NONE;
    end
  end

  // Storage write: a push lands at sp, a replace overwrites the current top.
  always_comb begin
    we_s    = 1'b0;
    waddr_s = AW'(sp_r);
    case (op_s)
      OP_PUSH: begin
        we_s    = 1'b1;
        waddr_s = AW'(sp_r);
      end
      OP_REPLACE: begin
        we_s    = 1'b1;
        waddr_s = AW'(sp_r - CW'(1));
      end
      default: begin
        we_s    = 1'b0;
        waddr_s = AW'(sp_r);
      end
    endcase
  end

  // Read address stays in range when empty; the value is masked anyway.
  always_comb begin
    if (empty_s) begin
      raddr_s = {AW{1'b0}};
    end else begin
      raddr_s = AW'(sp_r - CW'(1));
    end
  end

  stack_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk   (clk),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (din),
    .raddr (raddr_s),
    .rdata (rdata_s)
  );

  // Stack pointer and accepted-op pulse; rejected ops leave sp untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_r   <= {CW{1'b0}};
      done_r <= 1'b0;
    end else begin
      case (op_s)
        OP_CLEAR: begin
          sp_r   <= {CW{1'b0}};
          done_r <= 1'b1;
        end
        OP_PUSH: begin
          sp_r   <= sp_r + CW'(1);
          done_r <= 1'b1;
        end
        OP_POP: begin
          sp_r   <= sp_r - CW'(1);
          done_r <= 1'b1;
        end
        OP_REPLACE: begin
          done_r <= 1'b1;
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flags: a new error event wins over a simultaneous err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      if (op_s == OP_OVF) begin
        ovf_r <= 1'b1;
      end else if (err_clr) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
      if (op_s == OP_UNF) begin
        unf_r <= 1'b1;
      end else if (err_clr) begin
        unf_r <= 1'b0;
      end else begin
        unf_r <= unf_r;
      end
    end
  end

  assign top           = empty_s ? {WIDTH{1'b0}} : rdata_s;
  assign count         = sp_r;
  assign empty         = empty_s;
  assign full          = full_s;
  assign almost_full   = (sp_r >= CW'(AF_LEVEL));
  assign done          = done_r;
  assign err_overflow  = ovf_r;
  assign err_underflow = unf_r;

endmodule
